// File: rtl/inst_fetch_port.sv
// Instruction fetch port: turns PC-stage fetch requests into single-beat reads
// on a req/gnt/rvalid bus and presents the returned word to IF/ID.
module inst_fetch_port #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              ce_i,
  input  logic [5:0]        stall,
  input  logic              flush,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  output logic              stallreq_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  // IDLE    | free to request; stalls PC while ce_i is high
  // WAIT    | request granted, response pending
  // HOLD    | word presented to IF/ID until it is taken or flushed
  // DISCARD | flushed while pending; swallow the stale response
  typedef enum logic [1:0] {IDLE, WAIT, HOLD, DISCARD} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_buf_q, addr_buf_d;
  logic [DATA_W-1:0] data_buf_q, data_buf_d;

  // Only stall[1] (IF/ID hold) matters to this stage.
  logic unused_stall;
  assign unused_stall = ^{stall[5:2], stall[0]};

  assign mem_req_o  = (state_q == IDLE) && ce_i && !flush;
  assign mem_addr_o = pc_i;
  assign stallreq_o = ((state_q == IDLE) && ce_i) || (state_q == WAIT);
  assign inst_o     = (state_q == HOLD) ? data_buf_q : '0;
  assign inst_pc_o  = (state_q == HOLD) ? addr_buf_q : '0;

  always_comb begin
    state_d    = state_q;
    addr_buf_d = addr_buf_q;
    data_buf_d = data_buf_q;
    unique case (state_q)
      IDLE: begin
        if (mem_req_o && mem_gnt_i) begin
          addr_buf_d = pc_i;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (mem_rvalid_i) begin
          if (flush) begin
            state_d = IDLE;
          end else begin
            data_buf_d = mem_rdata_i;
            state_d    = HOLD;
          end
        end else if (flush) begin
          state_d = DISCARD;
        end
      end
      HOLD: begin
        if (flush || !stall[1]) begin
          data_buf_d = '0;
          addr_buf_d = '0;
          state_d    = IDLE;
        end
      end
      DISCARD: begin
        if (mem_rvalid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_buf_q <= '0;
      data_buf_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_buf_q <= addr_buf_d;
      data_buf_q <= data_buf_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch_port.sv
// Bench for inst_fetch_port: directed bus scenarios followed by randomized
// traffic, all checked each cycle against a transaction-level model.
module tb_inst_fetch_port;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_i = '0;
  logic        ce_i = 1'b0;
  logic [5:0]  stall = '0;
  logic        flush = 1'b0;
  logic [31:0] inst_o, inst_pc_o, mem_addr_o;
  logic        stallreq_o, mem_req_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;

  inst_fetch_port #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .ce_i(ce_i), .stall(stall), .flush(flush),
    .inst_o(inst_o), .inst_pc_o(inst_pc_o), .stallreq_o(stallreq_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  int    n_chk = 0;
  int    n_pass = 0;
  string phase = "reset";

  // Reference model: is a read in flight, is its answer still wanted,
  // and is a delivered word currently sitting in front of IF/ID.
  logic        m_busy = 0, m_want = 0, m_have = 0;
  logic [31:0] m_word = 0, m_pc = 0, m_req_pc = 0;
  logic        e_stall = 0;

  logic [31:0] obs_inst, obs_pc, obs_addr;
  logic        obs_req, obs_stall;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s/%s got=%h exp=%h", phase, tag, got, exp);
  endtask

  function automatic logic exp_req(input logic ce, input logic fl);
    return !m_have && !m_busy && ce && !fl;
  endfunction

  task automatic cycle(input logic r, input logic ce, input logic [31:0] pc, input logic st1,
                       input logic fl, input logic gnt, input logic rv, input logic [31:0] rd);
    logic [31:0] ei, ep;
    logic        er, es;
    @(negedge clk);
    rst = r; ce_i = ce; pc_i = pc; stall = {4'b0, st1, 1'b0}; flush = fl;
    mem_gnt_i = gnt; mem_rvalid_i = rv; mem_rdata_i = rd;
    #1;
    ei = m_have ? m_word : 32'h0;
    ep = m_have ? m_pc : 32'h0;
    if (m_have)      begin er = 0; es = 0; end
    else if (m_busy) begin er = 0; es = m_want; end
    else             begin er = ce && !fl; es = ce; end
    e_stall   = es;
    obs_inst  = inst_o;  obs_pc = inst_pc_o; obs_addr = mem_addr_o;
    obs_req   = mem_req_o; obs_stall = stallreq_o;
    if (!r) begin
      chk("inst", inst_o, ei);
      chk("inst_pc", inst_pc_o, ep);
      chk("req", {31'b0, mem_req_o}, {31'b0, er});
      chk("stallreq", {31'b0, stallreq_o}, {31'b0, es});
      if (er) chk("addr", mem_addr_o, pc);
    end
    @(posedge clk);
    if (r) begin
      m_busy = 0; m_want = 0; m_have = 0; m_word = 0; m_pc = 0;
    end else if (m_have) begin
      if (fl || !st1) m_have = 0;
    end else if (m_busy) begin
      if (rv) begin
        m_busy = 0;
        if (m_want && !fl) begin m_have = 1; m_word = rd; m_pc = m_req_pc; end
      end else if (fl) m_want = 0;
    end else if (ce && !fl && gnt) begin
      m_busy = 1; m_want = 1; m_req_pc = pc;
    end
  endtask

  logic [31:0] pc_cur;
  logic        fl_last;
  logic        bus_pend;
  int          bus_cnt;
  logic [31:0] bus_data;

  initial begin
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0);

    phase = "zero_wait";
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_inst", obs_inst, 32'h0);
    chk("rst_stall", {31'b0, obs_stall}, 32'h0);
    cycle(0, 1, 32'h0, 0, 0, 1, 0, 0);
    cycle(0, 1, 32'h0, 0, 0, 0, 1, 32'h3C010001);
    cycle(0, 1, 32'h0, 0, 0, 0, 0, 32'h0);
    chk("hold_inst", obs_inst, 32'h3C010001);
    chk("hold_stall", {31'b0, obs_stall}, 32'h0);
    cycle(0, 1, 32'h4, 0, 0, 1, 0, 0);
    chk("next_addr", obs_addr, 32'h4);
    chk("next_req", {31'b0, obs_req}, 32'h1);
    cycle(0, 1, 32'h4, 0, 0, 0, 1, 32'h24020005);
    cycle(0, 1, 32'h4, 0, 0, 0, 0, 0);

    phase = "slow_bus";
    for (int i = 0; i < 3; i++) cycle(0, 1, 32'h100, 0, 0, 0, 0, 0);
    cycle(0, 1, 32'h100, 0, 0, 1, 0, 0);
    cycle(0, 1, 32'h100, 0, 0, 0, 0, 32'h11111111);
    cycle(0, 1, 32'h100, 0, 0, 0, 1, 32'hA5A50100);
    cycle(0, 1, 32'h100, 0, 0, 0, 0, 0);
    chk("slow_inst", obs_inst, 32'hA5A50100);
    chk("slow_pc", obs_pc, 32'h100);

    phase = "flush_wait";
    cycle(0, 1, 32'h200, 0, 0, 1, 0, 0);
    cycle(0, 1, 32'h200, 0, 1, 0, 0, 0);
    cycle(0, 1, 32'h20, 0, 0, 0, 0, 0);
    chk("discard_stall", {31'b0, obs_stall}, 32'h0);
    cycle(0, 1, 32'h20, 0, 0, 0, 1, 32'hBADBAD00);
    chk("discard_req", {31'b0, obs_req}, 32'h0);
    chk("discard_inst", obs_inst, 32'h0);
    cycle(0, 1, 32'h20, 0, 0, 1, 0, 0);
    chk("refetch_req", {31'b0, obs_req}, 32'h1);
    chk("refetch_addr", obs_addr, 32'h20);
    cycle(0, 1, 32'h20, 0, 0, 0, 1, 32'h00000020);
    cycle(0, 1, 32'h20, 0, 0, 0, 0, 0);

    phase = "flush_rvalid";
    cycle(0, 1, 32'h300, 0, 0, 1, 0, 0);
    cycle(0, 1, 32'h300, 0, 1, 0, 1, 32'hDEAD0300);
    cycle(0, 0, 32'h40, 0, 0, 0, 0, 0);
    chk("drop_inst", obs_inst, 32'h0);

    phase = "hold_stall";
    cycle(0, 1, 32'h40, 0, 0, 1, 0, 0);
    cycle(0, 1, 32'h40, 1, 0, 0, 1, 32'h8C430040);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, 32'h44, 1, 0, 0, 0, 0);
      chk("held_inst", obs_inst, 32'h8C430040);
      chk("held_req", {31'b0, obs_req}, 32'h0);
    end
    cycle(0, 1, 32'h44, 0, 0, 0, 0, 0);
    cycle(0, 1, 32'h44, 0, 0, 0, 0, 0);
    chk("after_hold_req", {31'b0, obs_req}, 32'h1);

    phase = "rst_wait";
    cycle(0, 1, 32'h44, 0, 0, 1, 0, 0);
    cycle(0, 1, 32'h44, 0, 0, 0, 0, 0);
    cycle(1, 0, 32'h44, 0, 0, 0, 0, 0);
    cycle(0, 0, 32'h48, 0, 0, 0, 1, 32'hDEADBEEF);
    chk("stale_inst", obs_inst, 32'h0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 32'h48, 0, 0, 0, 0, 0);
    chk("idle_req", {31'b0, obs_req}, 32'h0);
    chk("idle_stall", {31'b0, obs_stall}, 32'h0);

    phase = "random";
    pc_cur = 32'h1000; fl_last = 0; bus_pend = 0; bus_cnt = 0; bus_data = 0;
    for (int i = 0; i < 3000; i++) begin
      logic ce, fl, st1, gnt, rv;
      logic [31:0] rd;
      if (!e_stall) pc_cur = fl_last ? ($urandom & 32'hFFFF_FFFC) : pc_cur + 32'h4;
      ce  = ($urandom_range(0, 7) != 0);
      fl  = ($urandom_range(0, 9) == 0);
      st1 = $urandom_range(0, 1) == 1;
      rv  = 0;
      rd  = $urandom;
      if (bus_pend) begin
        if (bus_cnt == 1) begin rv = 1; rd = bus_data; bus_pend = 0; end
        else bus_cnt--;
      end
      gnt = exp_req(ce, fl) && ($urandom_range(0, 2) == 0);
      if (gnt) begin
        bus_pend = 1; bus_cnt = $urandom_range(1, 3); bus_data = $urandom;
      end
      cycle(0, ce, pc_cur, st1, fl, gnt, rv, rd);
      fl_last = fl;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/inst_fetch_port.md
Name: inst_fetch_port

Overview:
- Instruction-side responder for the PC stage. It consumes the fetch address and chip enable from the PC and issues single-beat reads on a request/grant/response instruction bus.
- Returns the fetched word plus its address to the IF/ID register.
- Raises a stall request while a fetch is outstanding, so the PC holds its value until the instruction is delivered.

Parameters:
- ADDR_W, 32, fetch address width (matches InstAddrBus)
- DATA_W, 32, instruction width (matches InstBus)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- pc_i  in  ADDR_W  fetch address from PC stage
- ce_i  in  1  fetch enable from PC stage (0 = no fetch)
- stall  in  6  pipeline stall vector from control; stall[1]=1 means IF/ID is holding
- flush  in  1  exception/ERET flush; kills any fetch in progress
- inst_o  out  DATA_W  instruction to IF/ID
- inst_pc_o  out  ADDR_W  address of inst_o
- stallreq_o  out  1  stall request to control
- mem_req_o  out  1  bus read request
- mem_addr_o  out  ADDR_W  bus read address
- mem_gnt_i  in  1  bus accepted request this cycle
- mem_rvalid_i  in  1  read data valid this cycle
- mem_rdata_i  in  DATA_W  read data

Behaviour:
- Bus rules
  - At most one request outstanding.
  - mem_rvalid_i arrives ≥1 cycle after the granting cycle, and only for an accepted request.
  - While mem_req_o=1, mem_addr_o is held stable until mem_gnt_i.
- States: IDLE, WAIT, HOLD, DISCARD. Reset puts the block in IDLE.
- Reset values: inst_o=0, inst_pc_o=0, data/address buffers=0, stallreq_o=0, mem_req_o=0.
- IDLE
  - mem_req_o = ce_i & ~flush; mem_addr_o = pc_i; stallreq_o = ce_i.
  - mem_gnt_i while requesting: latch pc_i into addr_buf, go to WAIT.
  - Otherwise stay in IDLE; the request is re-driven next cycle, and pc_i is stable because stallreq_o holds the PC.
- WAIT
  - mem_req_o=0; stallreq_o=1.
  - mem_rvalid_i & ~flush: capture mem_rdata_i into data_buf, go to HOLD.
  - flush & mem_rvalid_i in the same cycle: drop the data, go to IDLE.
  - flush & ~mem_rvalid_i: go to DISCARD.
- HOLD
  - inst_o=data_buf; inst_pc_o=addr_buf; stallreq_o=0; mem_req_o=0.
  - flush: go to IDLE and drop the buffer.
  - Else stall[1]=0: go to IDLE (IF/ID captured the word at this edge).
  - Else stay in HOLD and keep presenting the word.
- DISCARD
  - mem_req_o=0; stallreq_o=0 (the flushed PC is not stalled).
  - On mem_rvalid_i, discard the data and go to IDLE.
  - No new request is issued until the stale response has returned.
- inst_o and inst_pc_o are 0 in every state except HOLD; IF/ID sees a NOP bubble.
- Latency with a zero-wait bus (gnt in the request cycle, rvalid the next cycle): request cycle, WAIT cycle, HOLD cycle. This gives 3 cycles per instruction, with stallreq_o high for the first 2.
- ce_i=0 in IDLE: no request, stallreq_o=0, remain in IDLE.
- ce_i is ignored in WAIT, HOLD and DISCARD.
- rst in any state returns to IDLE with all outputs at reset values on the next edge, even with a request in flight. A late mem_rvalid_i arriving in IDLE is ignored.
- No address alignment check; addresses pass through unmodified.

Test Plan:
- Reset, then ce_i=1, pc_i=0x0, gnt in the same cycle, rvalid=1 next cycle with rdata=0x3C010001 -> HOLD cycle shows inst_o=0x3C010001, inst_pc_o=0x0. stallreq_o=1 for exactly 2 cycles, then the next request goes out at pc_i=0x4.
- Bus with 3 cycles of gnt delay and 2 cycles of rvalid delay at pc_i=0x100 -> mem_req_o/mem_addr_o=0x100 held stable until gnt. stallreq_o stays high throughout. inst_o=rdata only in HOLD.
- flush asserted in WAIT without rvalid, rvalid arrives 2 cycles later -> goes to DISCARD with stallreq_o=0. The data never appears on inst_o. The next request is issued only in the cycle after rvalid, at the new pc_i=0x00000020.
- flush and rvalid in the same WAIT cycle -> data dropped, IDLE next cycle, inst_o stays 0.
- HOLD with stall[1]=1 for 4 cycles -> inst_o/inst_pc_o stable for all 4 cycles and mem_req_o=0. When stall[1] drops, return to IDLE after one edge.
- rst pulsed in WAIT, then a stale rvalid arrives in IDLE -> all outputs 0 and no capture. ce_i=0 after reset gives mem_req_o=0 and stallreq_o=0 indefinitely.
